// File: rtl/cmos_nvram_arbiter.sv
// Arbitrates the 1K x 4 CMOS RAM port between the Williams CPU and the HPS nvram path.
// Pauses and drains the CPU before the host owns the port, and requests autosave after CPU writes go quiet.
module cmos_nvram_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned QUIET_FRAMES = 60
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              hps_req,
    input  logic [ADDR_W-1:0] hps_addr,
    input  logic              hps_we,
    input  logic [7:0]        hps_din,
    output logic [7:0]        hps_dout,
    output logic              hps_grant,
    output logic              pause_req,
    input  logic              cpu_paused,
    input  logic              vblank,
    input  logic              autosave_en,
    output logic              autosave_req,
    output logic              dirty,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        PAUSE_WAIT,
        DRAIN,
        HOST,
        RELEASE
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(HOLD_CYC - 1);
    localparam logic [7:0] QUIET_MAX  = 8'(QUIET_FRAMES);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] drain_q;
    logic [3:0] drain_d;
    logic [7:0] quiet_cnt;
    logic       armed;
    logic       vblank_q;
    logic       in_idle;
    logic       in_host;
    logic       cpu_wr_ok;
    logic       vblank_rise;
    logic       fire;
    logic       unused_hps_hi;

    assign in_idle     = (state_q == IDLE);
    assign in_host     = (state_q == HOST);
    assign cpu_wr_ok   = cpu_we & in_idle;
    assign vblank_rise = vblank & ~vblank_q;
    assign fire        = armed & dirty & autosave_en & in_idle & (quiet_cnt == QUIET_MAX);
    assign unused_hps_hi = ^hps_din;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (hps_req) state_d = PAUSE_WAIT;
            end
            PAUSE_WAIT: begin
                if (!hps_req) begin
                    state_d = RELEASE;
                end else if (cpu_paused) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            DRAIN: begin
                if (!hps_req)            state_d = RELEASE;
                else if (drain_q == '0)  state_d = HOST;
                else                     drain_d = drain_q - 4'd1;
            end
            HOST: begin
                if (!hps_req) state_d = RELEASE;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Host ownership ends a dirty episode; an autosave pulse only disarms, it never clears dirty.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dirty        <= 1'b0;
            armed        <= 1'b0;
            quiet_cnt    <= '0;
            vblank_q     <= 1'b0;
            autosave_req <= 1'b0;
        end else begin
            vblank_q     <= vblank;
            autosave_req <= fire;
            if (in_host) begin
                dirty <= 1'b0;
                armed <= 1'b0;
            end else if (cpu_wr_ok) begin
                dirty <= 1'b1;
                armed <= 1'b1;
            end else if (fire) begin
                armed <= 1'b0;
            end
            if (cpu_wr_ok)
                quiet_cnt <= '0;
            else if (vblank_rise && (quiet_cnt < QUIET_MAX))
                quiet_cnt <= quiet_cnt + 8'd1;
        end
    end

    always_comb begin
        ram_addr  = cpu_addr;
        ram_din   = cpu_din;
        ram_we    = cpu_wr_ok;
        if (in_host) begin
            ram_addr = hps_addr;
            ram_din  = hps_din[DATA_W-1:0];
            ram_we   = hps_we;
        end
        hps_grant = in_host;
        pause_req = (state_q == PAUSE_WAIT) || (state_q == DRAIN) || in_host;
    end

    assign cpu_dout = ram_dout;
    assign hps_dout = 8'(ram_dout);

endmodule

// File: tb/tb_cmos_nvram_arbiter.sv
// Directed bench for cmos_nvram_arbiter: a behavioural model plus a backing RAM, checked every cycle,
// with literal expectations for grant timing, read-back data and autosave pulse placement.
module tb_cmos_nvram_arbiter;

    localparam int HOLD = 2;
    localparam int QF   = 60;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic [9:0] cpu_addr;
    logic       cpu_we;
    logic [3:0] cpu_din;
    logic [3:0] cpu_dout;
    logic       hps_req;
    logic [9:0] hps_addr;
    logic       hps_we;
    logic [7:0] hps_din;
    logic [7:0] hps_dout;
    logic       hps_grant;
    logic       pause_req;
    logic       cpu_paused;
    logic       vblank;
    logic       autosave_en;
    logic       autosave_req;
    logic       dirty;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [3:0] ram_din;
    logic [3:0] ram_dout;

    int total = 0;
    int bad   = 0;

    cmos_nvram_arbiter #(
        .ADDR_W(10), .DATA_W(4), .HOLD_CYC(HOLD), .QUIET_FRAMES(QF)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .hps_req(hps_req), .hps_addr(hps_addr), .hps_we(hps_we), .hps_din(hps_din),
        .hps_dout(hps_dout), .hps_grant(hps_grant), .pause_req(pause_req),
        .cpu_paused(cpu_paused), .vblank(vblank), .autosave_en(autosave_en),
        .autosave_req(autosave_req), .dirty(dirty),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    // Backing CMOS RAM with registered read (old data on a same-address write)
    logic [3:0] bram [1024];
    always @(posedge clk_sys) begin
        ram_dout <= bram[ram_addr];
        if (ram_we) bram[ram_addr] <= ram_din;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 waiting for pause ack, 2 draining, 3 host owns RAM, 4 releasing
    int         m_ph;
    int         m_el;
    int         m_edges;
    bit         m_dirty, m_armed, m_auto, m_vbq;
    logic [3:0] m_mem [1024];
    logic [3:0] m_rd;
    bit         mb_host, mb_idle, mb_we, mb_pulse;
    int         mb_a;
    logic [3:0] mb_d;

    always @(posedge clk_sys) begin
        mb_host = (m_ph == 3);
        mb_a  = mb_host ? int'(hps_addr) : int'(cpu_addr);
        mb_we = mb_host ? hps_we : (cpu_we && m_ph == 0);
        mb_d  = mb_host ? hps_din[3:0] : cpu_din;
        m_rd  = m_mem[mb_a];
        if (mb_we) m_mem[mb_a] = mb_d;
    end

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m_ph    <= 0;
            m_el    = 0;
            m_edges = 0;
            m_dirty = 0;
            m_armed = 0;
            m_auto  = 0;
            m_vbq   = 0;
        end else begin
            mb_idle  = (m_ph == 0);
            mb_pulse = m_armed && m_dirty && autosave_en && mb_idle && (m_edges >= QF);
            m_auto   = mb_pulse;
            if (m_ph == 3) begin
                m_dirty = 0;
                m_armed = 0;
            end else if (cpu_we && mb_idle) begin
                m_dirty = 1;
                m_armed = 1;
            end else if (mb_pulse) begin
                m_armed = 0;
            end
            if (cpu_we && mb_idle)       m_edges = 0;
            else if (vblank && !m_vbq)   m_edges++;
            m_vbq = vblank;
            case (m_ph)
                0: if (hps_req) m_ph <= 1;
                1: if (!hps_req) m_ph <= 4;
                   else if (cpu_paused) begin m_ph <= 2; m_el = 0; end
                2: if (!hps_req) m_ph <= 4;
                   else if (m_el == HOLD - 1) m_ph <= 3;
                   else m_el++;
                3: if (!hps_req) m_ph <= 4;
                default: m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk_sys) begin
        chk("hps_grant", hps_grant, m_ph == 3);
        chk("pause_req", pause_req, m_ph >= 1 && m_ph <= 3);
        chk("dirty", dirty, m_dirty);
        chk("autosave_req", autosave_req, m_auto);
        chk("ram_addr", ram_addr, (m_ph == 3) ? hps_addr : cpu_addr);
        chk("ram_we", ram_we, (m_ph == 3) ? hps_we : (cpu_we && m_ph == 0));
        chk("ram_din", ram_din, (m_ph == 3) ? hps_din[3:0] : cpu_din);
        chk("cpu_dout", cpu_dout, m_rd);
        chk("hps_dout", hps_dout, {4'h0, m_rd});
    end

    task automatic cyc();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [3:0] d);
        cpu_addr = a;
        cpu_din  = d;
        cpu_we   = 1'b1;
        cyc();
        cpu_we   = 1'b0;
    endtask

    // n vblank pulses of two cycles each; the single autosave pulse must follow edge fire_at
    task automatic edges(input int n, input int fire_at, input string nm);
        int seen = 0;
        for (int i = 1; i <= n; i++) begin
            vblank = 1'b1;
            cyc();
            vblank = 1'b0;
            settle();
            seen += int'(autosave_req);
            cyc();
            settle();
            seen += int'(autosave_req);
            if (i == fire_at) chk({nm, "_pulse_at_edge"}, autosave_req, 1'b1);
        end
        chk({nm, "_pulse_count"}, seen, (fire_at > 0 && fire_at <= n) ? 1 : 0);
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin
            cyc();
            n++;
            settle();
        end while (!hps_grant && n < 20);
    endtask

    int n;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bram[i]  = 4'h0;
            m_mem[i] = 4'h0;
        end
        ram_dout    = 4'h0;
        m_rd        = 4'h0;
        reset_n     = 1'b0;
        cpu_addr    = '0;
        cpu_we      = 1'b0;
        cpu_din     = '0;
        hps_req     = 1'b0;
        hps_addr    = '0;
        hps_we      = 1'b0;
        hps_din     = '0;
        cpu_paused  = 1'b0;
        vblank      = 1'b0;
        autosave_en = 1'b0;
        #22 reset_n = 1'b1;
        cyc();
        settle();
        chk("reset_grant", hps_grant, 1'b0);
        chk("reset_pause", pause_req, 1'b0);
        chk("reset_dirty", dirty, 1'b0);
        chk("reset_autosave", autosave_req, 1'b0);

        // 1) pause handshake and grant timing
        hps_req = 1'b1;
        cyc();
        settle();
        chk("t1_pause_req", pause_req, 1'b1);
        chk("t1_no_grant", hps_grant, 1'b0);
        cyc();
        cyc();
        cpu_paused = 1'b1;
        wait_grant(n);
        chk("t1_grant_latency", n, HOLD + 1);
        hps_addr = 10'h155;
        settle();
        chk("t1_ram_addr", ram_addr, 10'h155);

        // 2) host write/read, CPU writes blocked
        hps_addr = 10'h3FF;
        hps_din  = 8'hA7;
        hps_we   = 1'b1;
        settle();
        chk("t2_we", ram_we, 1'b1);
        chk("t2_din", ram_din, 4'h7);
        cyc();
        hps_we   = 1'b0;
        cpu_we   = 1'b1;
        cpu_addr = 10'h010;
        cpu_din  = 4'h9;
        settle();
        chk("t2_cpu_blocked", ram_we, 1'b0);
        cyc();
        cpu_we = 1'b0;
        settle();
        chk("t2_readback", hps_dout, 8'h07);
        chk("t2_dirty_clear", dirty, 1'b0);
        hps_req    = 1'b0;
        cpu_paused = 1'b0;
        cyc();
        settle();
        chk("t2_release_grant", hps_grant, 1'b0);
        chk("t2_release_pause", pause_req, 1'b0);
        cyc();

        // 3) write, then quiet period to autosave
        autosave_en = 1'b1;
        cpu_write(10'h010, 4'h5);
        settle();
        chk("t3_dirty", dirty, 1'b1);
        edges(70, QF, "t3");

        // 4) write coinciding with the 59th edge restarts the quiet count
        cpu_write(10'h011, 4'h3);
        edges(QF - 2, 0, "t4a");
        vblank   = 1'b1;
        cpu_addr = 10'h012;
        cpu_din  = 4'hC;
        cpu_we   = 1'b1;
        cyc();
        vblank   = 1'b0;
        cpu_we   = 1'b0;
        cyc();
        edges(QF, QF, "t4b");

        // autosave disabled at expiry: pulse is deferred until enabled
        cpu_write(10'h013, 4'h1);
        autosave_en = 1'b0;
        edges(QF + 2, 0, "t4c");
        autosave_en = 1'b1;
        cyc();
        settle();
        chk("t4_deferred_pulse", autosave_req, 1'b1);
        cyc();
        settle();
        chk("t4_deferred_once", autosave_req, 1'b0);

        // 5) aborted session keeps dirty; completed session clears it
        hps_req = 1'b1;
        cyc();
        settle();
        chk("t5_pause_up", pause_req, 1'b1);
        hps_req = 1'b0;
        cyc();
        settle();
        chk("t5_pause_down", pause_req, 1'b0);
        chk("t5_dirty_kept", dirty, 1'b1);
        cyc();
        hps_req = 1'b1;
        cyc();
        cpu_paused = 1'b1;
        wait_grant(n);
        chk("t5_grant_latency", n, HOLD + 1);
        cyc();
        settle();
        chk("t5_dirty_cleared", dirty, 1'b0);

        // 6) async reset while host owns the port
        reset_n = 1'b0;
        #1;
        chk("t6_grant", hps_grant, 1'b0);
        chk("t6_pause", pause_req, 1'b0);
        chk("t6_dirty", dirty, 1'b0);
        hps_req    = 1'b0;
        cpu_paused = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        cyc();
        settle();
        chk("t6_after_grant", hps_grant, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
